// File: rtl/mux4_rr_arbiter_if.sv
// Bus bundle between the four requesters and the round-robin arbiter/mux.
// The master side is the requester cluster; the slave side is the arbiter.
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 1
) ();
    logic [3:0]       req;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic [WIDTH-1:0] i3;
    logic [3:0]       gnt;
    logic             s1;
    logic             s0;
    logic             busy;
    logic [WIDTH-1:0] y;

    modport master (
        output req, i0, i1, i2, i3,
        input  gnt, s1, s0, busy, y
    );

    modport slave (
        input  req, i0, i1, i2, i3,
        output gnt, s1, s0, busy, y
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 data mux.
// One owner at a time, bounded hold, one dead cycle between grants.
module mux4_rr_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mux4_rr_arbiter_if.slave    bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Hold counter is 4 bits wide so the full 2..16 hold range fits.
    localparam logic [3:0] LAST_CNT = 4'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] sel_q,   sel_d;
    logic       busy_q,  busy_d;

    logic [1:0]       winner;
    logic [WIDTH-1:0] y_sel;

    // Pick the first requester at or after the pointer; scanning downward lets the nearest one win.
    always_comb begin
        winner = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[ptr_q + 2'(k)]) begin
                winner = ptr_q + 2'(k);
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, count hold time and release in GRANT.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    gnt_d   = 4'b0001 << winner;
                    sel_d   = winner;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!bus.req[sel_q] || (cnt_q == LAST_CNT)) begin
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + 2'd1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; a low rst_n at an edge drops any grant immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    // Unregistered data path: the owner's input reaches y directly, zero when idle.
    always_comb begin
        y_sel = '0;
        if (busy_q) begin
            case (sel_q)
                2'b00:   y_sel = bus.i0;
                2'b01:   y_sel = bus.i1;
                2'b10:   y_sel = bus.i2;
                default: y_sel = bus.i3;
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.s1   = sel_q[1];
    assign bus.s0   = sel_q[0];
    assign bus.busy = busy_q;
    assign bus.y    = y_sel;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios followed by random traffic,
// compared every cycle against an owner/pointer reference model.
module tb_mux4_rr_arbiter;

    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 8;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    // Reference model state: current owner (-1 = nobody), cycles owned so far,
    // next priority position and the last select value presented.
    int         mOwner;
    int         mRun;
    int         mPtr;
    logic [1:0] mSel;

    // Observed consecutive-grant run length, for the hold bound.
    int         obsRun;
    logic [3:0] prevGnt;

    mux4_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux4_rr_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the reference model by one rising edge using the sampled inputs.
    task automatic modelStep(input logic r, input logic [3:0] rq);
        if (!r) begin
            mOwner = -1;
            mRun   = 0;
            mPtr   = 0;
            mSel   = 2'b00;
        end else if (mOwner < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (mOwner < 0 && rq[(mPtr + k) % 4]) begin
                    mOwner = (mPtr + k) % 4;
                end
            end
            if (mOwner >= 0) begin
                mSel = 2'(mOwner);
                mRun = 1;
            end
        end else if (!rq[mOwner] || mRun == MAX_HOLD) begin
            mPtr   = (mOwner + 1) % 4;
            mOwner = -1;
            mRun   = 0;
        end else begin
            mRun = mRun + 1;
        end
    endtask

    // Compare every output against the model for the current cycle.
    task automatic checkOutput(input string tag);
        logic [3:0]       expGnt;
        logic             expBusy;
        logic [WIDTH-1:0] expY;
        expGnt  = (mOwner < 0) ? 4'b0000 : (4'b0001 << mOwner);
        expBusy = (mOwner >= 0);
        case (mOwner)
            0:       expY = bus.i0;
            1:       expY = bus.i1;
            2:       expY = bus.i2;
            3:       expY = bus.i3;
            default: expY = '0;
        endcase

        checks++;
        assert (bus.gnt === expGnt) else begin
            errors++;
            $error("[TB] FAIL %s gnt observed %b expected %b", tag, bus.gnt, expGnt);
        end
        checks++;
        assert ({bus.s1, bus.s0} === mSel) else begin
            errors++;
            $error("[TB] FAIL %s sel observed %b expected %b", tag, {bus.s1, bus.s0}, mSel);
        end
        checks++;
        assert (bus.busy === expBusy) else begin
            errors++;
            $error("[TB] FAIL %s busy observed %b expected %b", tag, bus.busy, expBusy);
        end
        checks++;
        assert (bus.y === expY) else begin
            errors++;
            $error("[TB] FAIL %s y observed %h expected %h", tag, bus.y, expY);
        end

        if (bus.gnt != 4'b0000 && bus.gnt == prevGnt) begin
            obsRun++;
        end else if (bus.gnt != 4'b0000) begin
            obsRun = 1;
        end else begin
            obsRun = 0;
        end
        prevGnt = bus.gnt;
        checks++;
        assert (obsRun <= MAX_HOLD) else begin
            errors++;
            $error("[TB] FAIL %s holdBound observed %0d expected at most %0d", tag, obsRun, MAX_HOLD);
        end
    endtask

    // Drive reset/request for one cycle, step the model on the edge, then check just after it.
    task automatic applyStimulus(input logic rstIn, input logic [3:0] reqIn, input string tag);
        rst_n   = rstIn;
        bus.req = reqIn;
        @(posedge clk);
        modelStep(rstIn, reqIn);
        #1;
        checkOutput(tag);
    endtask

    task automatic setData(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                           input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
        bus.i0 = d0;
        bus.i1 = d1;
        bus.i2 = d2;
        bus.i3 = d3;
    endtask

    // Directed scenarios first, then randomized traffic with occasional resets.
    initial begin
        logic [3:0] rq;
        int         runLeft;
        checks  = 0;
        errors  = 0;
        mOwner  = -1;
        mRun    = 0;
        mPtr    = 0;
        mSel    = 2'b00;
        obsRun  = 0;
        prevGnt = 4'b0000;
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        setData(4'h0, 4'h0, 4'h0, 4'h0);

        $display("[TB] reset with all requests high");
        setData(4'h5, 4'h6, 4'h7, 4'h8);
        applyStimulus(1'b0, 4'b1111, "rst0");
        applyStimulus(1'b0, 4'b1111, "rst1");
        applyStimulus(1'b1, 4'b1111, "firstGrant");
        applyStimulus(1'b1, 4'b0000, "firstRelease");
        applyStimulus(1'b1, 4'b0000, "firstIdle");

        $display("[TB] single request from requester 2");
        applyStimulus(1'b0, 4'b0000, "rstSingle");
        setData(4'h0, 4'h0, 4'h1, 4'h0);
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 4'b0100, "single");
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 4'b0000, "singleDrop");

        $display("[TB] round-robin with all requesters");
        applyStimulus(1'b0, 4'b0000, "rstRr");
        setData(4'hA, 4'hB, 4'hC, 4'hD);
        for (int c = 0; c < 5 * (MAX_HOLD + 1); c++) applyStimulus(1'b1, 4'b1111, "roundRobin");

        $display("[TB] lone requester timeout");
        applyStimulus(1'b0, 4'b0000, "rstLone");
        setData(4'h1, 4'h9, 4'h2, 4'h3);
        for (int c = 0; c < 20; c++) applyStimulus(1'b1, 4'b0010, "loneTimeout");

        $display("[TB] wrap and no preemption");
        applyStimulus(1'b0, 4'b0000, "rstWrap");
        setData(4'h4, 4'h0, 4'h0, 4'hE);
        for (int c = 0; c < 2; c++) applyStimulus(1'b1, 4'b1000, "owner3");
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 4'b1001, "noPreempt");
        for (int c = 0; c < 4; c++) applyStimulus(1'b1, 4'b0001, "wrapTo0");

        $display("[TB] reset in the middle of a grant");
        applyStimulus(1'b0, 4'b0000, "rstMid");
        setData(4'h0, 4'h7, 4'h0, 4'h0);
        for (int c = 0; c < 5; c++) applyStimulus(1'b1, 4'b0010, "owner1");
        applyStimulus(1'b0, 4'b0010, "midReset");
        for (int c = 0; c < 12; c++) applyStimulus(1'b1, 4'b0010, "regrant");

        $display("[TB] random traffic");
        applyStimulus(1'b0, 4'b0000, "rstRand");
        rq      = 4'b0000;
        runLeft = 0;
        for (int c = 0; c < 600; c++) begin
            if (runLeft == 0) begin
                rq      = 4'($urandom_range(0, 15));
                runLeft = $urandom_range(1, 12);
            end
            runLeft--;
            setData(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            applyStimulus(($urandom_range(0, 63) != 0), rq, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
